rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_pkg.sv | 31 +++
 rtl/decoder_3to8.sv | 17 +
 rtl/rr_arbiter_8.sv | 76 +++++++
 tb/tb_rr_arbiter_8.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// rtl/rr_arbiter_8_pkg.sv - shared widths, state encoding and rotating priority search
package rr_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Rotate req so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic                 found;
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> ptr);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        off   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - enable-gated binary to one-hot decoder
module decoder_3to8
  import rr_arbiter_8_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with hold limit and mandatory idle gap
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic [CNT_W-1:0]   busy_cnt
);

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic [NUM_REQ-1:0] others;
  logic               release_now;
  logic               timeout_now;

  assign others      = req & ~grant;
  assign release_now = ~req[grant_idx_q];
  assign timeout_now = (busy_cnt_q == CNT_W'(MAX_HOLD - 1)) && (|others);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    busy_cnt_d  = busy_cnt_q;
    if (state_q == ST_IDLE) begin
      if (|req) begin
        state_d     = ST_BUSY;
        grant_idx_d = rr_pick(req, ptr_q);
        busy_cnt_d  = '0;
      end
    end else begin
      // Release wins over timeout; both give the same next state and pointer.
      if (release_now || timeout_now) begin
        state_d     = ST_IDLE;
        ptr_d       = grant_idx_q + IDX_W'(1);
        grant_idx_d = '0;
        busy_cnt_d  = '0;
      end else if (busy_cnt_q != {CNT_W{1'b1}}) begin
        busy_cnt_d = busy_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign grant_valid = (state_q == ST_BUSY);
  assign grant_idx   = grant_idx_q;
  assign busy_cnt    = busy_cnt_q;

  decoder_3to8 u_dec (
    .en     (grant_valid),
    .idx    (grant_idx_q),
    .onehot (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - randomized and directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] g4, g16;
  logic [2:0] i4, i16;
  logic       v4, v16;
  logic [7:0] b4, b16;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int maxh[2] = '{4, 16};
  int m_owner[2] = '{-1, -1};
  int m_ptr[2] = '{0, 0};
  int m_hold[2] = '{0, 0};

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g4), .grant_idx(i4), .grant_valid(v4), .busy_cnt(b4)
  );

  rr_arbiter_8 #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g16), .grant_idx(i16), .grant_valid(v16), .busy_cnt(b16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who owns the resource, where the next search starts, how long it has been held.
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          m_owner[d] = -1;
          m_ptr[d]   = 0;
          m_hold[d]  = 0;
        end else if (m_owner[d] < 0) begin
          for (int k = 0; k < 8; k++) begin
            if (m_owner[d] < 0 && req[(m_ptr[d] + k) % 8]) begin
              m_owner[d] = (m_ptr[d] + k) % 8;
              m_hold[d]  = 0;
            end
          end
        end else begin
          if (!req[m_owner[d]] ||
              (m_hold[d] == maxh[d] - 1 && (req & ~(8'd1 << m_owner[d])) != 8'd0)) begin
            m_ptr[d]   = (m_owner[d] + 1) % 8;
            m_owner[d] = -1;
            m_hold[d]  = 0;
          end else if (m_hold[d] < 255) begin
            m_hold[d]++;
          end
        end
      end
    end
  end

  task automatic compare_one(input int d, input logic [7:0] g, input logic [2:0] i,
                             input logic v, input logic [7:0] b);
    bit        act;
    logic [7:0] eg;
    act = (m_owner[d] >= 0);
    eg  = act ? (8'd1 << m_owner[d]) : 8'd0;
    check($sformatf("model_grant[%0d]", d), 32'(g), 32'(eg));
    check($sformatf("model_idx[%0d]", d), 32'(i), act ? 32'(m_owner[d]) : 32'd0);
    check($sformatf("model_valid[%0d]", d), 32'(v), 32'(act));
    check($sformatf("model_busy[%0d]", d), 32'(b), act ? 32'(m_hold[d]) : 32'd0);
    check($sformatf("onehot_valid[%0d]", d),
          32'(((g & (g - 8'd1)) == 8'd0) && (v == (g != 8'd0))), 32'd1);
    assert (((g & (g - 8'd1)) == 8'd0) && (v == (g != 8'd0)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        compare_one(0, g4, i4, v4, b4);
        compare_one(1, g16, i16, v16, b16);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    step(2);
    chk_en = 1'b1;
    check("rst_grant", 32'(g4), 32'h0);
    check("rst_idx", 32'(i4), 32'h0);
    check("rst_valid", 32'(v4), 32'h0);
    check("rst_busy", 32'(b4), 32'h0);

    // Single requester, one-cycle latency, release drops grant next cycle
    rst_n = 1'b1;
    req   = 8'b0000_0100;
    step();
    check("lat_grant", 32'(g4), 32'h04);
    check("lat_idx", 32'(i4), 32'd2);
    req = 8'h00;
    step();
    check("rel_grant", 32'(g4), 32'h0);
    step();

    // Wrap from 7 to 0
    req = 8'h80;
    step();
    check("wrap_idx7", 32'(i4), 32'd7);
    req = 8'h81;
    step();
    check("wrap_hold7", 32'(i4), 32'd7);
    req = 8'h01;
    step();
    check("wrap_gap", 32'(v4), 32'd0);
    step();
    check("wrap_idx0", 32'(i4), 32'd0);
    check("wrap_valid0", 32'(v4), 32'd1);
    req = 8'h00;
    step(2);

    // All requesting, MAX_HOLD=4: 4 grant cycles then 1 idle, strict index order
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check("rr_idx", 32'(i4), 32'(g % 8));
        check("rr_busy", 32'(b4), 32'(c));
      end
      step();
      check("rr_gap", 32'(v4), 32'd0);
    end

    // Reset during a grant to 3
    rst_n = 1'b0;
    req   = 8'h00;
    step();
    rst_n = 1'b1;
    req   = 8'h08;
    step(2);
    check("pre_rst_idx", 32'(i4), 32'd3);
    rst_n = 1'b0;
    step();
    check("mid_rst_grant", 32'(g4), 32'h0);
    rst_n = 1'b1;
    req   = 8'b0000_1010;
    step();
    check("post_rst_idx", 32'(i4), 32'd1);

    // Sole requester keeps the grant past the hold limit; counter saturates
    rst_n = 1'b0;
    req   = 8'h00;
    step();
    rst_n = 1'b1;
    req   = 8'h20;
    step(40);
    check("hold_idx16", 32'(i16), 32'd5);
    check("hold_busy16", 32'(b16), 32'd39);
    check("hold_busy4", 32'(b4), 32'd39);
    step(260);
    check("sat_busy16", 32'(b16), 32'd255);
    req = 8'h00;
    step(2);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 7) == 0) req = 8'h00;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
